// File: rtl/branch_predictor_updater_pkg.sv
// Shared branch-predictor types: PHT/GHR paths, update entry, counter constants
// and the configuration values the predictor blocks take their defaults from.
package branch_predictor_updater_pkg;

   // Micro-architecture configuration
   localparam int unsigned CONF_PHT_ENTRY_NUM            = 2048;
   localparam int unsigned CONF_GLOBAL_HISTORY_BIT_WIDTH = 5;
   localparam int unsigned CONF_COMMIT_WIDTH             = 2;
   localparam int unsigned CONF_UPDATE_QUEUE_ENTRY_NUM   = 8;

   localparam int unsigned PHT_INDEX_BIT_WIDTH = $clog2(CONF_PHT_ENTRY_NUM);

   typedef logic [PHT_INDEX_BIT_WIDTH-1:0]           PHT_IndexPath;
   typedef logic [1:0]                               PHT_EntryPath;
   typedef logic [CONF_GLOBAL_HISTORY_BIT_WIDTH-1:0] BranchGlobalHistoryPath;

   typedef struct packed {
      PHT_IndexPath index;
      logic         taken;
   } BranchUpdateEntry;

   localparam PHT_EntryPath PHT_ENTRY_STRONGLY_NOT_TAKEN = 2'd0;
   localparam PHT_EntryPath PHT_ENTRY_STRONGLY_TAKEN     = 2'd3;

   // Saturating 2-bit counter step
   function automatic PHT_EntryPath pht_counter_next(input PHT_EntryPath old, input logic taken);
      PHT_EntryPath r;
      if (taken) r = (old == PHT_ENTRY_STRONGLY_TAKEN)     ? old : PHT_EntryPath'(old + 2'd1);
      else       r = (old == PHT_ENTRY_STRONGLY_NOT_TAKEN) ? old : PHT_EntryPath'(old - 2'd1);
      return r;
   endfunction

endpackage

// File: rtl/branch_predictor_updater_queue.sv
// Multi-push, single-pop circular queue of branch updates. Valid lanes are
// compressed so entries stay contiguous. The head entry is presented from a
// register loaded with the next-cycle head, so a push at cycle t is visible
// at the head output in cycle t+1.
module branch_update_queue
   import branch_predictor_updater_pkg::*;
#(
   parameter  int unsigned ENTRY_NUM = CONF_UPDATE_QUEUE_ENTRY_NUM,
   parameter  int unsigned WIDTH     = CONF_COMMIT_WIDTH,
   parameter  int unsigned IW        = PHT_INDEX_BIT_WIDTH,
   localparam int unsigned CW        = $clog2(ENTRY_NUM + 1)
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [WIDTH-1:0]    i_push_valid,
   input  logic [WIDTH*IW-1:0] i_push_index,
   input  logic [WIDTH-1:0]    i_push_taken,
   input  logic                i_pop,
   output logic                o_ready,
   output logic [CW-1:0]       o_count,
   output logic                o_head_valid,
   output logic [IW-1:0]       o_head_index,
   output logic                o_head_taken
);
   localparam int unsigned PW = $clog2(ENTRY_NUM);

   typedef struct packed {
      logic [IW-1:0] index;
      logic          taken;
   } entry_t;

   entry_t           r_mem [ENTRY_NUM];
   logic [PW-1:0]    r_head, r_tail, w_head_next;
   logic [CW-1:0]    r_count, w_count_next, w_remain;
   logic             r_head_valid;
   entry_t           r_head_entry, w_head_entry_next;
   logic [WIDTH-1:0] w_accept;
   entry_t           w_cmp [WIDTH];
   int unsigned      w_num;
   logic             w_pop;

   assign o_ready      = (ENTRY_NUM - 32'(r_count)) >= WIDTH;
   assign o_count      = r_count;
   assign o_head_valid = r_head_valid;
   assign o_head_index = r_head_entry.index;
   assign o_head_taken = r_head_entry.taken;

   // Compress accepted lanes into consecutive slots, preserving lane order
   always_comb begin
      w_accept = i_push_valid & {WIDTH{o_ready}};
      w_num    = 0;
      for (int unsigned k = 0; k < WIDTH; k++) w_cmp[k] = '0;
      for (int unsigned l = 0; l < WIDTH; l++) begin
         if (w_accept[l]) begin
            for (int unsigned k = 0; k < WIDTH; k++) begin
               if (k == w_num) begin
                  w_cmp[k].index = i_push_index[l*IW +: IW];
                  w_cmp[k].taken = i_push_taken[l];
               end
            end
            w_num = w_num + 1;
         end
      end
   end

   // Next occupancy and next head entry (from storage, or bypassed from this cycle's first push)
   always_comb begin
      w_pop             = i_pop && r_head_valid;
      w_head_next       = r_head + PW'(w_pop);
      w_remain          = r_count - CW'(w_pop);
      w_count_next      = w_remain + CW'(w_num);
      w_head_entry_next = (w_remain != '0) ? r_mem[w_head_next] : w_cmp[0];
   end

   // Entry storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < WIDTH; k++) begin
         if (k < w_num) r_mem[r_tail + PW'(k)] <= w_cmp[k];
      end
   end

   // Pointers, occupancy and registered head
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head       <= '0;
         r_tail       <= '0;
         r_count      <= '0;
         r_head_valid <= 1'b0;
         r_head_entry <= '0;
      end else begin
         r_head       <= w_head_next;
         r_tail       <= r_tail + PW'(w_num);
         r_count      <= w_count_next;
         r_head_valid <= (w_count_next != '0);
         r_head_entry <= w_head_entry_next;
      end
   end

endmodule

// File: rtl/branch_predictor_updater.sv
// Commit-side PHT updater: queues resolved branch outcomes, runs a two-stage
// read-modify-write on the PHT update port with W->R forwarding, and keeps
// the committed global history.
module branch_predictor_updater
   import branch_predictor_updater_pkg::*;
#(
   parameter  int unsigned PHT_ENTRY_NUM            = CONF_PHT_ENTRY_NUM,
   parameter  int unsigned GLOBAL_HISTORY_BIT_WIDTH = CONF_GLOBAL_HISTORY_BIT_WIDTH,
   parameter  int unsigned UPDATE_WIDTH             = CONF_COMMIT_WIDTH,
   parameter  int unsigned QUEUE_ENTRY_NUM          = CONF_UPDATE_QUEUE_ENTRY_NUM,
   localparam int unsigned IW                       = $clog2(PHT_ENTRY_NUM),
   localparam int unsigned GW                       = GLOBAL_HISTORY_BIT_WIDTH
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic [UPDATE_WIDTH-1:0]    upd_valid,
   input  logic [UPDATE_WIDTH*IW-1:0] upd_index,
   input  logic [UPDATE_WIDTH-1:0]    upd_taken,
   output logic                       upd_ready,
   output logic                       pht_rd_en,
   output logic [IW-1:0]              pht_rd_addr,
   input  logic [1:0]                 pht_rd_data,
   output logic                       pht_wr_en,
   output logic [IW-1:0]              pht_wr_addr,
   output logic [1:0]                 pht_wr_data,
   output logic [GW-1:0]              commit_ghr,
   output logic                       queue_empty
);
   localparam int unsigned CW = $clog2(QUEUE_ENTRY_NUM + 1);

   logic [CW-1:0] w_count;
   logic          w_rd_valid;
   logic [IW-1:0] w_rd_index;
   logic          w_rd_taken;

   logic          r_w_valid;
   logic [IW-1:0] r_w_index;
   logic          r_w_taken;
   logic          r_fwd_valid;
   PHT_EntryPath  r_fwd_data;
   PHT_EntryPath  w_old;
   logic [GW-1:0] r_ghr, w_ghr_next;

   branch_update_queue #(
      .ENTRY_NUM (QUEUE_ENTRY_NUM),
      .WIDTH     (UPDATE_WIDTH),
      .IW        (IW)
   ) u_queue (
      .clk          (clk),
      .rst          (rst),
      .i_push_valid (upd_valid),
      .i_push_index (upd_index),
      .i_push_taken (upd_taken),
      .i_pop        (w_rd_valid),
      .o_ready      (upd_ready),
      .o_count      (w_count),
      .o_head_valid (w_rd_valid),
      .o_head_index (w_rd_index),
      .o_head_taken (w_rd_taken)
   );

   // R stage is the registered queue head; it is consumed every cycle it is valid
   assign pht_rd_en   = w_rd_valid;
   assign pht_rd_addr = w_rd_index;
   assign pht_wr_en   = r_w_valid;
   assign pht_wr_addr = r_w_index;
   assign commit_ghr  = r_ghr;
   assign queue_empty = (w_count == '0) && !r_w_valid;

   // W stage: the counter read returns during this stage, so the write data is
   // formed from it directly; a same-index write last cycle overrides the stale read
   always_comb begin
      w_old       = r_fwd_valid ? r_fwd_data : pht_rd_data;
      pht_wr_data = r_w_valid ? pht_counter_next(w_old, r_w_taken) : '0;
   end

   // Committed history: shift in each accepted lane's outcome in lane order
   always_comb begin
      w_ghr_next = r_ghr;
      for (int unsigned l = 0; l < UPDATE_WIDTH; l++) begin
         if (upd_valid[l] && upd_ready) w_ghr_next = {w_ghr_next[GW-2:0], upd_taken[l]};
      end
   end

   // R->W pipeline register, forwarding capture and GHR
   always_ff @(posedge clk) begin
      if (rst) begin
         r_w_valid   <= 1'b0;
         r_w_index   <= '0;
         r_w_taken   <= 1'b0;
         r_fwd_valid <= 1'b0;
         r_fwd_data  <= '0;
         r_ghr       <= '0;
      end else begin
         r_w_valid   <= w_rd_valid;
         r_w_index   <= w_rd_index;
         r_w_taken   <= w_rd_taken;
         r_fwd_valid <= r_w_valid && w_rd_valid && (r_w_index == w_rd_index);
         r_fwd_data  <= pht_wr_data;
         r_ghr       <= w_ghr_next;
      end
   end

endmodule

// File: tb/tb_branch_predictor_updater.sv
// Directed bench for branch_predictor_updater with a PHT memory model and an
// in-order scoreboard of expected PHT writes.
module tb_branch_predictor_updater;
   import branch_predictor_updater_pkg::*;

   localparam int unsigned IW = 11;
   localparam int unsigned GW = 5;
   localparam int unsigned UW = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [UW-1:0]    upd_valid = '0;
   logic [UW*IW-1:0] upd_index = '0;
   logic [UW-1:0]    upd_taken = '0;
   logic             upd_ready, pht_rd_en, pht_wr_en, queue_empty;
   logic [IW-1:0]    pht_rd_addr, pht_wr_addr;
   logic [1:0]       pht_rd_data, pht_wr_data;
   logic [GW-1:0]    commit_ghr;

   always #5 clk = ~clk;

   branch_predictor_updater #(
      .PHT_ENTRY_NUM            (2048),
      .GLOBAL_HISTORY_BIT_WIDTH (GW),
      .UPDATE_WIDTH             (UW),
      .QUEUE_ENTRY_NUM          (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .upd_valid   (upd_valid),
      .upd_index   (upd_index),
      .upd_taken   (upd_taken),
      .upd_ready   (upd_ready),
      .pht_rd_en   (pht_rd_en),
      .pht_rd_addr (pht_rd_addr),
      .pht_rd_data (pht_rd_data),
      .pht_wr_en   (pht_wr_en),
      .pht_wr_addr (pht_wr_addr),
      .pht_wr_data (pht_wr_data),
      .commit_ghr  (commit_ghr),
      .queue_empty (queue_empty)
   );

   typedef struct {
      PHT_IndexPath addr;
      PHT_EntryPath data;
   } exp_t;

   exp_t          sb[$];
   exp_t          mon_e;
   logic [1:0]    pht_mem [2048];
   logic [1:0]    ref_pht [2048];
   logic [GW-1:0] ghr_m = '0;
   int            tests = 0;
   int            fails = 0;
   int            bp_waits = 0;
   logic          pre_en = 1'b0;
   logic [IW-1:0] pre_addr = '0;
   logic [1:0]    pre_data = '0;

   // PHT update port: registered read returns pre-write data
   always @(posedge clk) begin
      if (pht_rd_en) pht_rd_data <= pht_mem[pht_rd_addr];
      if (pht_wr_en) pht_mem[pht_wr_addr] <= pht_wr_data;
      if (pre_en)    pht_mem[pre_addr] <= pre_data;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] sat(input logic [1:0] v, input logic t);
      if (t) return (v == 2'd3) ? 2'd3 : v + 2'd1;
      return (v == 2'd0) ? 2'd0 : v - 2'd1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [IW-1:0] a, input logic [1:0] d);
      pre_addr = a;
      pre_data = d;
      pre_en   = 1'b1;
      ref_pht[a] = d;
      step();
      pre_en = 1'b0;
   endtask

   task automatic send(input logic [1:0] v, input logic [IW-1:0] i0, input logic t0,
                       input logic [IW-1:0] i1, input logic t1);
      int unsigned   guard = 0;
      logic [IW-1:0] ix [2];
      logic          tk [2];
      logic [1:0]    e;
      ix[0] = i0; ix[1] = i1; tk[0] = t0; tk[1] = t1;
      while (v != 2'b00 && !upd_ready && guard < 40) begin
         bp_waits++;
         step();
         guard++;
      end
      if (guard == 40) check("ready_timeout", 32'(upd_ready), 32'd1);
      upd_valid = v;
      upd_index = {i1, i0};
      upd_taken = {t1, t0};
      for (int l = 0; l < 2; l++) begin
         if (v[l]) begin
            e = sat(ref_pht[ix[l]], tk[l]);
            ref_pht[ix[l]] = e;
            sb.push_back('{addr: ix[l], data: e});
            ghr_m = {ghr_m[GW-2:0], tk[l]};
         end
      end
      step();
      upd_valid = '0;
   endtask

   task automatic drain();
      int unsigned guard = 0;
      while (!(queue_empty && sb.size() == 0) && guard < 200) begin
         step();
         guard++;
      end
      check("drain_queue_empty", 32'(queue_empty), 32'd1);
      check("drain_sb_empty", 32'(sb.size()), 32'd0);
   endtask

   // Protocol check and in-order write scoreboard
   always @(negedge clk) begin
      if (|upd_valid) check("protocol_ready", 32'(upd_ready), 32'd1);
      if (pht_wr_en === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_write", {19'd0, pht_wr_addr, pht_wr_data}, 32'hFFFF_FFFF);
         end else begin
            mon_e = sb.pop_front();
            check("wr_addr", 32'(pht_wr_addr), 32'(mon_e.addr));
            check("wr_data", 32'(pht_wr_data), 32'(mon_e.data));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      rst = 1'b1;
      step();
      step();
      check("rst_rd_en", 32'(pht_rd_en), 32'd0);
      check("rst_wr_en", 32'(pht_wr_en), 32'd0);
      check("rst_ready", 32'(upd_ready), 32'd1);
      check("rst_empty", 32'(queue_empty), 32'd1);
      check("rst_ghr", 32'(commit_ghr), 32'd0);
      check("rst_rd_addr", 32'(pht_rd_addr), 32'd0);
      check("rst_wr_addr", 32'(pht_wr_addr), 32'd0);
      check("rst_wr_data", 32'(pht_wr_data), 32'd0);
      rst = 1'b0;
      step();

      // Single update: read at t+1, write at t+2
      preload(11'd5, 2'd1);
      send(2'b01, 11'd5, 1'b1, 11'd0, 1'b0);
      check("single_rd_en", 32'(pht_rd_en), 32'd1);
      check("single_rd_addr", 32'(pht_rd_addr), 32'd5);
      check("single_wr_en_early", 32'(pht_wr_en), 32'd0);
      step();
      check("single_wr_en", 32'(pht_wr_en), 32'd1);
      check("single_wr_addr", 32'(pht_wr_addr), 32'd5);
      check("single_wr_data", 32'(pht_wr_data), 32'd2);
      drain();

      // Saturation at both ends
      preload(11'd9, 2'd3);
      send(2'b01, 11'd9, 1'b1, 11'd0, 1'b0);
      drain();
      preload(11'd9, 2'd0);
      send(2'b01, 11'd9, 1'b0, 11'd0, 1'b0);
      drain();

      // Forwarding across three back-to-back same-index updates
      preload(11'd7, 2'd0);
      send(2'b11, 11'd7, 1'b1, 11'd7, 1'b1);
      send(2'b01, 11'd7, 1'b1, 11'd0, 1'b0);
      check("fwd_wr0", 32'({pht_wr_en, pht_wr_data}), 32'({1'b1, 2'd1}));
      step();
      check("fwd_wr1", 32'({pht_wr_en, pht_wr_data}), 32'({1'b1, 2'd2}));
      step();
      check("fwd_wr2", 32'({pht_wr_en, pht_wr_data}), 32'({1'b1, 2'd3}));
      drain();

      // GHR lane ordering
      rst = 1'b1;
      step();
      rst = 1'b0;
      ghr_m = '0;
      sb.delete();
      check("ghr_after_rst", 32'(commit_ghr), 32'd0);
      preload(11'd20, 2'd1);
      preload(11'd21, 2'd2);
      preload(11'd22, 2'd0);
      send(2'b11, 11'd20, 1'b1, 11'd21, 1'b0);
      check("ghr_two_lanes", 32'(commit_ghr), 32'b00010);
      send(2'b10, 11'd0, 1'b0, 11'd22, 1'b1);
      check("ghr_lane1_only", 32'(commit_ghr), 32'b00101);
      drain();

      // Back-pressure with dual-lane traffic over a few hot indices
      for (int i = 30; i < 34; i++) preload(IW'(i), 2'($urandom_range(0, 3)));
      bp_waits = 0;
      for (int n = 0; n < 14; n++) begin
         send(2'b11, IW'(30 + $urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     IW'(30 + $urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      check("bp_ready_dropped", 32'(bp_waits > 0), 32'd1);
      check("bp_ghr", 32'(commit_ghr), 32'(ghr_m));
      drain();

      // Reset with 4 queued updates and one in the W stage
      for (int i = 100; i < 106; i++) preload(IW'(i), 2'd1);
      send(2'b11, 11'd100, 1'b1, 11'd101, 1'b1);
      send(2'b11, 11'd102, 1'b0, 11'd103, 1'b0);
      send(2'b11, 11'd104, 1'b1, 11'd105, 1'b1);
      check("pre_rst_wr_en", 32'(pht_wr_en), 32'd1);
      check("pre_rst_wr_addr", 32'(pht_wr_addr), 32'd101);
      check("pre_rst_empty", 32'(queue_empty), 32'd0);
      rst = 1'b1;
      step();
      sb.delete();
      ghr_m = '0;
      check("midrst_wr_en", 32'(pht_wr_en), 32'd0);
      check("midrst_rd_en", 32'(pht_rd_en), 32'd0);
      check("midrst_empty", 32'(queue_empty), 32'd1);
      check("midrst_ghr", 32'(commit_ghr), 32'd0);
      check("midrst_ready", 32'(upd_ready), 32'd1);
      rst = 1'b0;
      repeat (4) step();

      // Normal operation resumes after reset
      preload(11'd40, 2'd2);
      send(2'b01, 11'd40, 1'b0, 11'd0, 1'b0);
      drain();
      check("final_ghr", 32'(commit_ghr), 32'(ghr_m));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
